// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//
// Instruction fetch stage in front of the instruction register / decoder.
// Issues sequential word-aligned fetches to instruction memory, collects the
// in-order responses into a small prefetch FIFO, and hands instructions to
// decode together with their PCs. A redirect (branch / jal / jalr) flushes the
// FIFO and marks every still-outstanding response as stale so it is thrown
// away when it returns. Halt permanently stops new fetches until reset.
//
// Handshakes (valid/ready): a transfer happens on a rising clock edge exactly
// when valid and ready are both high in that cycle. A source holding valid
// high keeps its payload stable until the transfer happens. Responses from
// memory carry no ready: they are always taken, at most one per cycle.
//
// Ports
//   clock            in   system clock, all state updates on the rising edge
//   reset            in   synchronous, active-high reset
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_req_addr    out  word-aligned fetch address (bits [1:0] = 0)
//   imem_resp_valid  in   response valid, in request order
//   imem_resp_data   in   instruction word of the response
//   redirect_valid   in   one-cycle pulse: flush and refetch from target
//   redirect_target  in   new PC, bits [1:0] ignored
//   halt             in   stop issuing fetches, sticky until reset
//   instr_valid      out  FIFO head valid
//   instr_data       out  FIFO head instruction
//   instr_pc         out  PC of the FIFO head
//   instr_ready      in   decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Architectural state
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic          r_halted;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [63:0]   r_fifo [DEPTH];   // {pc, instruction}

  // Combinational control
  logic [CW:0]   w_credit_sum;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp;
  logic          w_drop_now;
  logic          w_push;
  logic          w_pop;
  logic          w_instr_valid;
  logic [31:0]   w_redirect_pc;
  logic [63:0]   w_head;

  // Queued plus outstanding fetches never exceed DEPTH, so every response
  // that is not being dropped always has a free FIFO slot waiting for it.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};

  assign w_req_valid = !reset && !r_halted && !halt && !redirect_valid &&
                       (w_credit_sum < DEPTH_W);
  assign w_accept    = w_req_valid && imem_req_ready;

  // A response with nothing outstanding is ignored so inflight cannot wrap.
  assign w_resp      = imem_resp_valid && (r_inflight != '0);
  assign w_drop_now  = w_resp && (r_drop != '0);

  // A redirect empties the FIFO, so a same-cycle push or pop is void.
  assign w_push      = w_resp && (r_drop == '0) && !redirect_valid;
  assign w_instr_valid = !reset && (r_count != '0);
  assign w_pop       = w_instr_valid && instr_ready && !redirect_valid;

  assign w_redirect_pc = redirect_target & 32'hFFFF_FFFC;
  assign w_head        = r_fifo[r_rd_ptr];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = w_instr_valid;
  assign instr_pc       = w_head[63:32];
  assign instr_data     = w_head[31:0];

  // Control and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (halt) begin
        r_halted <= 1'b1;
      end

      // Outstanding fetches follow accepts and responses in every case,
      // including the redirect cycle.
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);

      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        // Everything still outstanding after this edge belongs to the old
        // stream and must be discarded when it returns.
        r_drop     <= r_inflight + CW'(w_accept) - CW'(w_resp);
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        r_drop  <= r_drop - CW'(w_drop_now);
      end
    end
  end

  // FIFO storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {r_resp_pc, imem_resp_data};
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction register and decode logic. It generates sequential word addresses to instruction memory over a valid/ready request channel and collects in-order responses into a small prefetch FIFO. Decode consumes instructions from the FIFO with their PCs attached. Branch, jal and jalr redirects flush the FIFO and discard stale in-flight responses; halt stops further fetching.

Parameters:
DEPTH, 4, prefetch FIFO entries and the maximum of queued plus in-flight fetches (power of two, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address, bits [1:0] always 0
imem_resp_valid  input  1  response data valid, in request order, ≥1 cycle after acceptance
imem_resp_data  input  32  instruction word
redirect_valid  input  1  one-cycle pulse: flush and refetch from redirect_target
redirect_target  input  32  new PC; bits [1:0] ignored and forced to 0
halt  input  1  stop issuing fetches; sticky until reset
instr_valid  output  1  FIFO head valid
instr_data  output  32  FIFO head instruction
instr_pc  output  32  PC of FIFO head
instr_ready  input  1  decode consumes head this cycle

Behaviour:
- Reset (synchronous, when reset=1 at a clock edge): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, inflight=0, drop=0, halted=0. While reset=1, imem_req_valid=0 and instr_valid=0. The earliest request goes out in the cycle after reset deasserts. Reset mid-operation discards all state, including in-flight responses: post-reset responses are accepted as new data, so the bench must not assert resp_valid for pre-reset requests.
- Request: imem_req_valid = !reset && !halted && !halt && !redirect_valid && (count + inflight < DEPTH). imem_req_addr = fetch_pc.
- Accept = imem_req_valid && imem_req_ready. On accept: fetch_pc += 4 (32-bit wrap), inflight += 1. Address and valid stay stable while ready=0.
- Response handling, at most one per cycle:
  - When drop > 0: discard, drop -= 1, inflight -= 1.
  - Otherwise: push {resp_pc, data}, resp_pc += 4, inflight -= 1.
  - The FIFO can never overflow, because of the credit rule.
- Pop: instr_valid && instr_ready. Push and pop in the same cycle are both performed, and count is unchanged. instr_valid = count != 0. instr_data and instr_pc come combinationally from the head entry.
- Redirect, with priority over everything else:
  - FIFO emptied; any same-cycle pop or push is ignored.
  - fetch_pc = resp_pc = {redirect_target[31:2], 2'b00}.
  - drop = inflight + accept_this_cycle − resp_valid_this_cycle. Accept is 0 by construction, because req_valid is low during redirect.
  - inflight is adjusted as normal.
  - The first post-redirect request appears in the next cycle.
- Halt: halted is set on the edge where halt=1 and stays set until reset. No new requests are issued. Outstanding responses are still accepted and the FIFO still drains. A redirect while halted still flushes and updates the PCs but issues no fetch.
- Counters: count is clog2(DEPTH)+1 bits; inflight and drop are each clog2(DEPTH)+1 bits. Invariants: count + inflight ≤ DEPTH and drop ≤ inflight.
- Throughput: with ready=1 and 1-cycle response latency, one instruction per cycle is sustained once the FIFO is primed.

Test Plan:
1. Reset, then ready=1 with 1-cycle response latency and instr_ready=1 → request addresses are 0, 4, 8, 12. instr_pc follows the sequence 0, 4, 8 with matching data. instr_valid first rises 2 cycles after reset deasserts.
2. Hold instr_ready=0 → after DEPTH=4 accepted requests, req_valid drops and stays low. Then set instr_ready=1 → the queue drains in order and requests resume at address 16.
3. With 2 responses in flight, pulse redirect to 0x103 → FIFO empties. The next 2 responses are discarded and instr_valid stays 0 for them. The next request address is 0x100, and the first delivered instr_pc is 0x100.
4. Redirect in the same cycle as a response and a pop → that response is dropped. instr_valid=0 in the next cycle. drop equals the remaining inflight count.
5. Assert halt with 1 request in flight → no further req_valid. The in-flight instruction is still delivered. A later redirect produces no requests until reset.
6. Hold imem_req_ready=0 for 3 cycles → imem_req_addr and imem_req_valid stay stable. fetch_pc increments only on the accepting cycle. Back-to-back push and pop keep count constant.
